// File: rtl/param_conv_engine_if.sv
// Handshake and data bus of param_conv_engine: start/image/kernel in, results and status out.
interface param_conv_engine_if #(
    parameter int DATA_W = 8,
    parameter int IMG_N  = 4,
    parameter int KER_K  = 3
);
    localparam int RW = (IMG_N > 1) ? $clog2(IMG_N) : 1;

    logic                             start;
    logic [IMG_N*IMG_N*DATA_W-1:0]    img;
    logic [KER_K*KER_K*DATA_W-1:0]    ker;
    logic                             busy;
    logic                             out_valid;
    logic [DATA_W-1:0]                out_data;
    logic [RW-1:0]                    out_row;
    logic [RW-1:0]                    out_col;
    logic                             done;

    modport slave (
        input  start, img, ker,
        output busy, out_valid, out_data, out_row, out_col, done
    );

    modport master (
        output start, img, ker,
        input  busy, out_valid, out_data, out_row, out_col, done
    );
endinterface

// File: rtl/param_conv_engine.sv
// Sequential 2-D true convolution with one shared multiplier (IDLE/MAC/EMIT/DONE).
// Define CONV_SAT_EN to clamp results at 2^DATA_W-1 instead of truncating.
module param_conv_engine #(
    parameter int DATA_W = 8,
    parameter int IMG_N  = 4,
    parameter int KER_K  = 3,
    parameter int ACC_W  = 20
) (
    input  logic               clk,
    input  logic               rst,
    param_conv_engine_if.slave bus
);
    localparam int M  = IMG_N - KER_K + 1;
    localparam int KW = (KER_K > 1) ? $clog2(KER_K) : 1;
    localparam int RW = (IMG_N > 1) ? $clog2(IMG_N) : 1;
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [IMG_N*IMG_N*DATA_W-1:0] r_img;
    logic [KER_K*KER_K*DATA_W-1:0] r_ker;
    logic [ACC_W-1:0]              r_acc;
    logic [KW-1:0]                 r_p;
    logic [KW-1:0]                 r_q;
    logic [RW-1:0]                 r_row;
    logic [RW-1:0]                 r_col;
    logic [DATA_W-1:0]             r_out_data;
    logic [RW-1:0]                 r_out_row;
    logic [RW-1:0]                 r_out_col;

    logic [31:0]                   w_img_idx;
    logic [31:0]                   w_ker_idx;
    logic [DATA_W-1:0]             w_pix;
    logic [DATA_W-1:0]             w_wgt;
    logic [PW-1:0]                 w_prod;
    logic [ACC_W-1:0]              w_sum;
    logic [DATA_W-1:0]             w_res;
    logic                          w_last_term;
    logic                          w_last_out;

    // Kernel is read flipped in both axes to give true convolution.
    always_comb begin
        w_img_idx = ((32'(r_row) + 32'(r_p)) * 32'(IMG_N) + 32'(r_col) + 32'(r_q)) * 32'(DATA_W);
        w_ker_idx = ((32'(KER_K - 1) - 32'(r_p)) * 32'(KER_K) + 32'(KER_K - 1) - 32'(r_q)) * 32'(DATA_W);
        w_pix     = r_img[w_img_idx +: DATA_W];
        w_wgt     = r_ker[w_ker_idx +: DATA_W];
        w_prod    = PW'(w_pix) * PW'(w_wgt);
        w_sum     = r_acc + ACC_W'(w_prod);
        w_last_term = (r_p == KW'(KER_K - 1)) && (r_q == KW'(KER_K - 1));
        w_last_out  = (r_row == RW'(M - 1)) && (r_col == RW'(M - 1));
    end

`ifdef CONV_SAT_EN
    always_comb begin
        w_res = (|w_sum[ACC_W-1:DATA_W]) ? '1 : w_sum[DATA_W-1:0];
    end
`else
    always_comb begin
        w_res = w_sum[DATA_W-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_MAC;
            S_MAC:   if (w_last_term) w_next = S_EMIT;
            S_EMIT:  w_next = w_last_out ? S_DONE : S_MAC;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (r_state != S_IDLE);
        bus.out_valid = (r_state == S_EMIT);
        bus.done      = (r_state == S_DONE);
        bus.out_data  = r_out_data;
        bus.out_row   = r_out_row;
        bus.out_col   = r_out_col;
    end

    // Result and coordinates are registered on the last MAC edge so they hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_img      <= '0;
            r_ker      <= '0;
            r_acc      <= '0;
            r_p        <= '0;
            r_q        <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_out_data <= '0;
            r_out_row  <= '0;
            r_out_col  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_img <= bus.img;
                        r_ker <= bus.ker;
                        r_acc <= '0;
                        r_p   <= '0;
                        r_q   <= '0;
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= w_sum;
                    if (w_last_term) begin
                        r_p        <= '0;
                        r_q        <= '0;
                        r_out_data <= w_res;
                        r_out_row  <= r_row;
                        r_out_col  <= r_col;
                    end else if (r_q == KW'(KER_K - 1)) begin
                        r_q <= '0;
                        r_p <= r_p + KW'(1);
                    end else begin
                        r_q <= r_q + KW'(1);
                    end
                end
                S_EMIT: begin
                    r_acc <= '0;
                    if (r_col == RW'(M - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + RW'(1);
                    end else begin
                        r_col <= r_col + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_param_conv_engine.sv
// Directed self-checking bench for param_conv_engine at default parameters.
module tb_param_conv_engine;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int K  = 3;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    param_conv_engine_if #(.DATA_W(DW), .IMG_N(N), .KER_K(K)) bus ();

    param_conv_engine #(
        .DATA_W(DW),
        .IMG_N (N),
        .KER_K (K),
        .ACC_W (AW)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic launch(input logic [N*N*DW-1:0] im, input logic [K*K*DW-1:0] kr);
        @(negedge clk);
        bus.img   = im;
        bus.ker   = kr;
        bus.start = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the accept edge; cycle n is the n-th negedge after it.
    task automatic wait_op(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input bit hold, input logic [N*N*DW-1:0] next_img);
        logic [7:0] exp_d [4];
        int         k;
        bit         seen_done;
        bit         prev_v;
        logic [7:0] last_d;
        logic [1:0] last_r;
        logic [1:0] last_c;
        exp_d = '{e0, e1, e2, e3};
        k = 0; seen_done = 0; prev_v = 0; last_d = '0; last_r = '0; last_c = '0;
        for (int n = 1; n <= 60 && !seen_done; n++) begin
            @(negedge clk);
            if (n == 1) check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (hold) bus.img = {4{$urandom()}};
            else      bus.start = 1'b0;
            if (prev_v && !bus.out_valid) begin
                check_eq({tag, "_hold_d"}, 32'(bus.out_data), 32'(last_d));
                check_eq({tag, "_hold_rc"}, 32'({bus.out_row, bus.out_col}), 32'({last_r, last_c}));
            end
            if (bus.out_valid) begin
                if (k < 4) begin
                    last_d = exp_d[k];
                    last_r = 2'(k / 2);
                    last_c = 2'(k % 2);
                    check_eq($sformatf("%s_d%0d", tag, k), 32'(bus.out_data), 32'(last_d));
                    check_eq($sformatf("%s_r%0d", tag, k), 32'(bus.out_row), 32'(last_r));
                    check_eq($sformatf("%s_c%0d", tag, k), 32'(bus.out_col), 32'(last_c));
                end
                k++;
            end
            prev_v = bus.out_valid;
            if (bus.done) begin
                seen_done = 1;
                check_eq({tag, "_lat"}, 32'(n), 32'd41);
                check_eq({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
                if (hold) bus.img = next_img;
            end
        end
        check_eq({tag, "_seen_done"}, 32'(seen_done), 32'd1);
        check_eq({tag, "_nout"}, 32'(k), 32'd4);
    endtask

    logic [N*N*DW-1:0] img_ones, img_pat, img_dot, img_max;
    logic [K*K*DW-1:0] ker_ones, ker_ctr, ker_corner, ker_max;
    int                stray;

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.img   = '0;
        bus.ker   = '0;
        img_pat   = '0;
        for (int i = 0; i < N * N; i++) begin
            img_ones[i*DW +: DW] = 8'd1;
            img_max[i*DW +: DW]  = 8'hFF;
            img_pat[i*DW +: DW]  = 8'(i + 1);
        end
        img_dot = '0;
        img_dot[7:0] = 8'd1;
        ker_ctr = '0;
        ker_corner = '0;
        for (int i = 0; i < K * K; i++) begin
            ker_ones[i*DW +: DW] = 8'd1;
            ker_max[i*DW +: DW]  = 8'hFF;
        end
        ker_ctr[4*DW +: DW]    = 8'd1;
        ker_corner[8*DW +: DW] = 8'd5;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_rc", 32'({bus.out_row, bus.out_col}), 32'd0);
        rst = 1'b0;

        launch(img_ones, ker_ones);
        wait_op("ones", 8'd9, 8'd9, 8'd9, 8'd9, 1'b0, '0);
        @(negedge clk);
        check_eq("ones_done_pulse", 32'(bus.done), 32'd0);
        check_eq("ones_idle", 32'(bus.busy), 32'd0);

        launch(img_pat, ker_ctr);
        wait_op("ctr", 8'd6, 8'd7, 8'd10, 8'd11, 1'b0, '0);

        launch(img_dot, ker_corner);
        wait_op("flip", 8'd5, 8'd0, 8'd0, 8'd0, 1'b0, '0);

`ifdef CONV_SAT_EN
        launch(img_max, ker_max);
        wait_op("max", 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, '0);
`else
        launch(img_max, ker_max);
        wait_op("max", 8'd9, 8'd9, 8'd9, 8'd9, 1'b0, '0);
`endif

        launch(img_ones, ker_ones);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_done", 32'(bus.done), 32'd0);
        check_eq("abort_data", 32'(bus.out_data), 32'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.busy || bus.out_valid || bus.done) stray++;
        end
        check_eq("abort_quiet", 32'(stray), 32'd0);
        launch(img_pat, ker_ctr);
        wait_op("after_rst", 8'd6, 8'd7, 8'd10, 8'd11, 1'b0, '0);

        launch(img_pat, ker_ctr);
        wait_op("held", 8'd6, 8'd7, 8'd10, 8'd11, 1'b1, img_ones);
        @(negedge clk);
        check_eq("held_idle", 32'(bus.busy), 32'd0);
        wait_op("held2", 8'd1, 8'd1, 8'd1, 8'd1, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
